// File: rtl/rcvr_frame_ctrl.sv
// rcvr_frame_ctrl: receive MAC frame parser with address filter, CRC-8 check and
// a payload FIFO whose writes stay tentative until the frame is judged good.
module rcvr_frame_ctrl #(
   parameter int         DEPTH = 256,
   parameter logic [7:0] BCAST = 8'h2A
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] mac,
   input  logic [7:0] ack_addr,
   input  logic [7:0] rdata,
   input  logic       rvalid,
   input  logic       cardet,
   input  logic       rerror,
   input  logic       ack_sent,
   input  logic       rrd,
   output logic [7:0] dout,
   output logic       rrdy,
   output logic       ACK_needed,
   output logic [7:0] ack_frame_addr,
   output logic       ACK_received,
   output logic       frame_good,
   output logic [3:0] rerrcnt
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [2:0] {IDLE, DEST, SRC, TYPE, DATA, DROP, CHECK} state_t;

   state_t      state_q, state_d;
   logic [7:0]  dest_q, dest_d, src_q, src_d, type_q, type_d, crc_q, crc_d;
   logic [7:0]  ack_frame_addr_q, ack_frame_addr_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [AW:0] rptr_q, rptr_d, wptr_q, wptr_d, tptr_q, tptr_d;
   logic        ack_needed_q, ack_needed_d, ack_rcv_q, ack_rcv_d, good_q, good_d;
   logic [3:0]  errcnt_q, errcnt_d;
   logic [7:0]  mem_q [DEPTH];
   logic        we, err, full, bad, for_us, is_data;

   function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
      logic [7:0] r;
      r = c ^ b;
      for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      return r;
   endfunction

   assign rrdy           = rptr_q != wptr_q;
   assign dout           = rrdy ? mem_q[rptr_q[AW-1:0]] : 8'h00;
   assign ACK_needed     = ack_needed_q;
   assign ack_frame_addr = ack_frame_addr_q;
   assign ACK_received   = ack_rcv_q;
   assign frame_good     = good_q;
   assign rerrcnt        = errcnt_q;

   // Tentative bytes count against the reader, so committed data is never overwritten
   assign full    = (tptr_q[AW] != rptr_q[AW]) && (tptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign is_data = (type_q == 8'h30) || (type_q == 8'h32);
   assign bad     = (cnt_q == 2'd0) || (crc_q != 8'h00) ||
                    !(is_data || type_q == 8'h33) || (type_q == 8'h33 && cnt_q != 2'd1);
   assign for_us  = (dest_q == mac) || (dest_q == BCAST);

   always_comb begin
      state_d          = state_q;
      dest_d           = dest_q;
      src_d            = src_q;
      type_d           = type_q;
      crc_d            = crc_q;
      cnt_d            = cnt_q;
      tptr_d           = tptr_q;
      wptr_d           = wptr_q;
      rptr_d           = (rrd && rrdy) ? rptr_q + 1'b1 : rptr_q;
      ack_needed_d     = ack_sent ? 1'b0 : ack_needed_q;
      ack_frame_addr_d = ack_frame_addr_q;
      ack_rcv_d        = 1'b0;
      good_d           = 1'b0;
      we               = 1'b0;
      err              = 1'b0;
      case (state_q)
         IDLE: if (cardet) begin
            state_d = DEST;
            crc_d   = 8'h00;
            cnt_d   = 2'd0;
            tptr_d  = wptr_q;
         end
         DEST, SRC, TYPE, DATA: if (rerror) state_d = DROP;
         else begin
            if (rvalid) begin
               crc_d = crc8(crc_q, rdata);
               if (state_q == DEST) begin
                  dest_d  = rdata;
                  state_d = SRC;
               end else if (state_q == SRC) begin
                  src_d   = rdata;
                  state_d = TYPE;
               end else if (state_q == TYPE) begin
                  type_d  = rdata;
                  state_d = DATA;
               end else if (full) state_d = DROP;
               else begin
                  we     = 1'b1;
                  tptr_d = tptr_q + 1'b1;
                  cnt_d  = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
               end
            end
            if (!cardet && state_d != DROP) state_d = CHECK;
         end
         DROP: if (!cardet) begin
            state_d = IDLE;
            err     = 1'b1;
         end
         CHECK: begin
            state_d = IDLE;
            if (bad) err = 1'b1;
            else if (for_us && is_data) begin
               wptr_d = tptr_q - 1'b1;
               good_d = 1'b1;
               if (type_q == 8'h32 && dest_q == mac) begin
                  ack_needed_d     = 1'b1;
                  ack_frame_addr_d = src_q;
               end
            end else if (for_us) ack_rcv_d = (dest_q == mac) && (src_q == ack_addr);
         end
         default: state_d = IDLE;
      endcase
      errcnt_d = (err && errcnt_q != 4'hF) ? errcnt_q + 4'd1 : errcnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= IDLE;
         dest_q           <= 8'h00;
         src_q            <= 8'h00;
         type_q           <= 8'h00;
         crc_q            <= 8'h00;
         cnt_q            <= 2'd0;
         rptr_q           <= '0;
         wptr_q           <= '0;
         tptr_q           <= '0;
         ack_needed_q     <= 1'b0;
         ack_frame_addr_q <= 8'h00;
         ack_rcv_q        <= 1'b0;
         good_q           <= 1'b0;
         errcnt_q         <= 4'h0;
      end else begin
         state_q          <= state_d;
         dest_q           <= dest_d;
         src_q            <= src_d;
         type_q           <= type_d;
         crc_q            <= crc_d;
         cnt_q            <= cnt_d;
         rptr_q           <= rptr_d;
         wptr_q           <= wptr_d;
         tptr_q           <= tptr_d;
         ack_needed_q     <= ack_needed_d;
         ack_frame_addr_q <= ack_frame_addr_d;
         ack_rcv_q        <= ack_rcv_d;
         good_q           <= good_d;
         errcnt_q         <= errcnt_d;
      end
   end

   always_ff @(posedge clk) if (we) mem_q[tptr_q[AW-1:0]] <= rdata;
endmodule

// File: tb/tb_rcvr_frame_ctrl.sv
// tb_rcvr_frame_ctrl: directed frames against a 4-deep receiver, CRC computed by the bench.
module tb_rcvr_frame_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] mac = 8'h41, ack_addr = 8'h00, rdata = 8'h00;
   logic       rvalid = 1'b0, cardet = 1'b0, rerror = 1'b0, ack_sent = 1'b0, rrd = 1'b0;
   logic [7:0] dout, ack_frame_addr;
   logic       rrdy, ACK_needed, ACK_received, frame_good;
   logic [3:0] rerrcnt;
   int         errors = 0, checks = 0;
   logic [7:0] fb[$];

   rcvr_frame_ctrl #(.DEPTH(4), .BCAST(8'h2A)) dut (
      .clk(clk), .rst(rst), .mac(mac), .ack_addr(ack_addr), .rdata(rdata),
      .rvalid(rvalid), .cardet(cardet), .rerror(rerror), .ack_sent(ack_sent), .rrd(rrd),
      .dout(dout), .rrdy(rrdy), .ACK_needed(ACK_needed), .ack_frame_addr(ack_frame_addr),
      .ACK_received(ACK_received), .frame_good(frame_good), .rerrcnt(rerrcnt)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
      logic [7:0] r;
      r = c ^ b;
      for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rvalid = 1'b1;
      rdata  = b;
      tick();
      rvalid = 1'b0;
      tick();
   endtask

   task automatic send_bytes();
      cardet = 1'b1;
      tick();
      foreach (fb[i]) send_byte(fb[i]);
   endtask

   // Sends fb plus its CRC (xor cx to corrupt), then drops cardet for one sampled edge
   task automatic send_frame(input logic [7:0] cx);
      logic [7:0] c;
      c = 8'h00;
      foreach (fb[i]) c = crc8(c, fb[i]);
      send_bytes();
      send_byte(c ^ cx);
      cardet = 1'b0;
      tick();
   endtask

   task automatic pop();
      rrd = 1'b1;
      tick();
      rrd = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      chk("rst_dout", dout, 8'h00);
      chk("rst_rrdy", rrdy, 1'b0);
      chk("rst_ackn", ACK_needed, 1'b0);
      chk("rst_ackaddr", ack_frame_addr, 8'h00);
      chk("rst_ackrcv", ACK_received, 1'b0);
      chk("rst_good", frame_good, 1'b0);
      chk("rst_errcnt", rerrcnt, 4'h0);
      rst = 1'b1;
      tick();

      fb = '{8'h41, 8'h42, 8'h30, 8'h48, 8'h49};
      send_frame(8'h00);
      chk("good_early", frame_good, 1'b0);
      tick();
      chk("good_pulse", frame_good, 1'b1);
      chk("good_rrdy", rrdy, 1'b1);
      chk("good_dout0", dout, 8'h48);
      tick();
      chk("good_end", frame_good, 1'b0);
      pop();
      chk("pop_dout1", dout, 8'h49);
      chk("pop_rrdy1", rrdy, 1'b1);
      pop();
      chk("pop_empty", rrdy, 1'b0);
      chk("good_errcnt", rerrcnt, 4'h0);

      send_frame(8'h01);
      tick();
      chk("crc_nogood", frame_good, 1'b0);
      chk("crc_rrdy", rrdy, 1'b0);
      chk("crc_errcnt", rerrcnt, 4'h1);
      for (int n = 0; n < 14; n++) begin
         send_frame(8'h01);
         tick();
      end
      chk("errcnt_15", rerrcnt, 4'hF);
      send_frame(8'h01);
      tick();
      chk("errcnt_sat", rerrcnt, 4'hF);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("errcnt_clr", rerrcnt, 4'h0);

      fb = '{8'h41, 8'h42, 8'h32, 8'h55};
      send_frame(8'h00);
      tick();
      chk("ackreq_good", frame_good, 1'b1);
      chk("ackreq_need", ACK_needed, 1'b1);
      chk("ackreq_addr", ack_frame_addr, 8'h42);
      chk("ackreq_dout", dout, 8'h55);
      ack_sent = 1'b1;
      tick();
      ack_sent = 1'b0;
      chk("acksent_clr", ACK_needed, 1'b0);
      pop();
      chk("ackreq_empty", rrdy, 1'b0);

      fb = '{8'h2A, 8'h42, 8'h32, 8'h66};
      send_frame(8'h00);
      tick();
      chk("bcast_good", frame_good, 1'b1);
      chk("bcast_noack", ACK_needed, 1'b0);
      chk("bcast_dout", dout, 8'h66);
      pop();

      ack_addr = 8'h42;
      fb = '{8'h41, 8'h42, 8'h33};
      send_frame(8'h00);
      chk("ackrcv_early", ACK_received, 1'b0);
      tick();
      chk("ackrcv_pulse", ACK_received, 1'b1);
      chk("ackrcv_nogood", frame_good, 1'b0);
      chk("ackrcv_fifo", rrdy, 1'b0);
      tick();
      chk("ackrcv_end", ACK_received, 1'b0);
      fb = '{8'h41, 8'h43, 8'h33};
      send_frame(8'h00);
      tick();
      chk("ackrcv_wrongsrc", ACK_received, 1'b0);
      chk("ackrcv_errcnt", rerrcnt, 4'h0);

      fb = '{8'h50, 8'h42, 8'h30, 8'h77};
      send_frame(8'h00);
      tick();
      chk("filter_good", frame_good, 1'b0);
      chk("filter_rrdy", rrdy, 1'b0);
      chk("filter_errcnt", rerrcnt, 4'h0);

      fb = '{8'h41, 8'h42, 8'h30, 8'hA1, 8'hA2};
      send_frame(8'h00);
      tick();
      fb = '{8'h41, 8'h42, 8'h30, 8'hB1};
      send_bytes();
      rerror = 1'b1;
      tick();
      rerror = 1'b0;
      cardet = 1'b0;
      tick();
      tick();
      chk("rerr_errcnt", rerrcnt, 4'h1);
      chk("rerr_nogood", frame_good, 1'b0);
      chk("rerr_rrdy", rrdy, 1'b1);
      chk("rerr_dout0", dout, 8'hA1);
      pop();
      chk("rerr_dout1", dout, 8'hA2);
      pop();
      chk("rerr_empty", rrdy, 1'b0);

      fb = '{8'h41, 8'h42, 8'h30, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
      send_frame(8'h00);
      tick();
      chk("ovf_nogood", frame_good, 1'b0);
      chk("ovf_errcnt", rerrcnt, 4'h2);
      chk("ovf_rrdy", rrdy, 1'b0);

      fb = '{8'h41, 8'h42, 8'h30, 8'hC1, 8'hC2, 8'hC3};
      send_frame(8'h00);
      tick();
      chk("fit_good", frame_good, 1'b1);
      chk("fit_dout0", dout, 8'hC1);
      pop();
      chk("fit_dout1", dout, 8'hC2);
      pop();
      chk("fit_dout2", dout, 8'hC3);
      pop();
      chk("fit_empty", rrdy, 1'b0);
      chk("fit_errcnt", rerrcnt, 4'h2);

      fb = '{8'h41, 8'h42, 8'h30};
      send_bytes();
      cardet = 1'b0;
      tick();
      tick();
      chk("runt_nogood", frame_good, 1'b0);
      chk("runt_errcnt", rerrcnt, 4'h3);

      fb = '{8'h41, 8'h42, 8'h32, 8'hD1};
      send_frame(8'h00);
      tick();
      chk("pre_rst_rrdy", rrdy, 1'b1);
      chk("pre_rst_ackn", ACK_needed, 1'b1);
      fb = '{8'h41, 8'h42, 8'h30, 8'hE1};
      send_bytes();
      rst = 1'b0;
      #1;
      chk("arst_dout", dout, 8'h00);
      chk("arst_rrdy", rrdy, 1'b0);
      chk("arst_ackn", ACK_needed, 1'b0);
      chk("arst_ackaddr", ack_frame_addr, 8'h00);
      chk("arst_ackrcv", ACK_received, 1'b0);
      chk("arst_good", frame_good, 1'b0);
      chk("arst_errcnt", rerrcnt, 4'h0);
      cardet = 1'b0;
      tick();
      rst = 1'b1;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
